// File: rtl/pc_sequencer.sv
// Fetch program counter sequencer: sequential step, branch and exception redirects, valid/ready fetch handshake.
// Optional macro PC_SEQ_ALIGN_CHECK_EN replaces misaligned branch targets with EXC_VECTOR and pulses misalign_err.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int unsigned STEP       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic        req_ready,
    output logic        req_valid,
    output logic [31:0] fetch_pc,
    output logic        redirect_pending,
    output logic        misalign_err
);

    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_STALL = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pend_tgt_q, pend_tgt_d;
    logic              pend_q, pend_d;
    logic              pend_exc_q, pend_exc_d;
    logic              req_valid_q, req_valid_d;
    logic              mis_q, mis_d;

    logic              redir_c;
    logic              mis_c;
    logic              redir_exc_c;
    logic [PC_W-1:0]   redir_tgt_c;
    logic [PC_W-1:0]   pc_step_c;

    // Resolve this cycle's redirect; a misaligned branch is promoted to an exception-class redirect.
    always_comb begin
        redir_c = exc_valid | br_valid;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        mis_c = br_valid & ~exc_valid & (br_target[1:0] != 2'b00);
`else
        mis_c = 1'b0;
`endif
        redir_exc_c = exc_valid | mis_c;
        redir_tgt_c = redir_exc_c ? EXC_VECTOR : br_target;
        pc_step_c   = pc_q + PC_W'(STEP);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        pend_exc_d = pend_exc_q;
        mis_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_ISSUE;
                pend_d  = 1'b0;
                if (redir_c) begin
                    pc_d  = redir_tgt_c;
                    mis_d = mis_c;
                end
            end
            S_ISSUE: begin
                if (req_ready) begin
                    if (redir_c) begin
                        pc_d  = redir_tgt_c;
                        mis_d = mis_c;
                    end else if (pend_q) begin
                        pc_d = pend_tgt_q;
                    end else begin
                        pc_d = pc_step_c;
                    end
                    pend_d     = 1'b0;
                    pend_exc_d = 1'b0;
                    state_d    = stall ? S_STALL : S_ISSUE;
                end else if (redir_c && (!pend_q || !pend_exc_q || redir_exc_c)) begin
                    // A pending exception is never displaced by a later branch.
                    pend_d     = 1'b1;
                    pend_tgt_d = redir_tgt_c;
                    pend_exc_d = redir_exc_c;
                    mis_d      = mis_c;
                end
            end
            S_STALL: begin
                if (redir_c) begin
                    pc_d       = redir_tgt_c;
                    pend_d     = 1'b0;
                    pend_exc_d = 1'b0;
                    mis_d      = mis_c;
                end
                if (!stall) begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_valid_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pend_tgt_q  <= '0;
            pend_exc_q  <= 1'b0;
            req_valid_q <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_exc_q  <= pend_exc_d;
            req_valid_q <= req_valid_d;
            mis_q       <= mis_d;
        end
    end

    assign req_valid        = req_valid_q;
    assign fetch_pc         = pc_q;
    assign redirect_pending = pend_q;
    assign misalign_err     = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expected values are hand-computed per vector.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_valid;
    logic        req_ready;
    logic        req_valid;
    logic [31:0] fetch_pc;
    logic        redirect_pending;
    logic        misalign_err;

    int n_checks;
    int n_errors;

    pc_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .br_valid         (br_valid),
        .br_target        (br_target),
        .exc_valid        (exc_valid),
        .req_ready        (req_ready),
        .req_valid        (req_valid),
        .fetch_pc         (fetch_pc),
        .redirect_pending (redirect_pending),
        .misalign_err     (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic rv, input logic [31:0] pc, input logic pend);
        check({tag, ".req_valid"}, 32'(req_valid), 32'(rv));
        check({tag, ".fetch_pc"}, fetch_pc, pc);
        check({tag, ".pending"}, 32'(redirect_pending), 32'(pend));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_target = 32'h0;
        exc_valid = 1'b0;
        req_ready = 1'b0;

        #2;
        chk_state("reset", 1'b0, 32'h0, 1'b0);
        check("reset.misalign", 32'(misalign_err), 32'h0);
        tick();
        tick();
        chk_state("reset_held", 1'b0, 32'h0, 1'b0);

        // Sequential fetch with req_ready held high.
        reset     = 1'b1;
        req_ready = 1'b1;
        tick();
        chk_state("seq0", 1'b1, 32'h0, 1'b0);
        tick();
        check("seq4", fetch_pc, 32'h4);
        tick();
        check("seq8", fetch_pc, 32'h8);
        tick();
        check("seqC", fetch_pc, 32'hC);
        tick();
        check("seq10", fetch_pc, 32'h10);

        // Branch latched while fetch is not ready.
        req_ready = 1'b0;
        tick();
        chk_state("hold1", 1'b1, 32'h10, 1'b0);
        br_valid  = 1'b1;
        br_target = 32'h200;
        tick();
        br_valid  = 1'b0;
        chk_state("hold2", 1'b1, 32'h10, 1'b1);
        tick();
        chk_state("hold3", 1'b1, 32'h10, 1'b1);
        req_ready = 1'b1;
        tick();
        chk_state("br_accept", 1'b1, 32'h200, 1'b0);
        tick();
        check("br_step", fetch_pc, 32'h204);

        // Pending branch overwritten by exception; later branch ignored.
        req_ready = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h300;
        tick();
        chk_state("pend_br", 1'b1, 32'h204, 1'b1);
        br_valid  = 1'b0;
        exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h500;
        tick();
        br_valid  = 1'b0;
        req_ready = 1'b1;
        check("pend_exc.pc", fetch_pc, 32'h204);
        tick();
        chk_state("exc_accept", 1'b1, 32'h80, 1'b0);
        tick();
        check("exc_step", fetch_pc, 32'h84);

        // Same-cycle redirect on acceptance, then stall for four cycles.
        br_valid  = 1'b1;
        br_target = 32'h40;
        tick();
        br_valid = 1'b0;
        check("br_direct", fetch_pc, 32'h40);
        stall = 1'b1;
        tick();
        chk_state("stall1", 1'b0, 32'h44, 1'b0);
        tick();
        tick();
        tick();
        chk_state("stall4", 1'b0, 32'h44, 1'b0);
        stall = 1'b0;
        tick();
        chk_state("unstall", 1'b1, 32'h44, 1'b0);

        // Redirect applied directly while stalled.
        stall = 1'b1;
        tick();
        chk_state("stall_b", 1'b0, 32'h48, 1'b0);
        br_valid  = 1'b1;
        br_target = 32'h700;
        tick();
        br_valid = 1'b0;
        chk_state("stall_redir", 1'b0, 32'h700, 1'b0);
        stall = 1'b0;
        tick();
        chk_state("stall_exit", 1'b1, 32'h700, 1'b0);

        // Wrap at the top of the address space.
        br_valid  = 1'b1;
        br_target = 32'hFFFF_FFFC;
        tick();
        br_valid = 1'b0;
        check("wrap_load", fetch_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap", fetch_pc, 32'h0);
        tick();
        check("wrap_step", fetch_pc, 32'h4);

        // Asynchronous reset mid-ISSUE.
        reset = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 32'h0, 1'b0);
        tick();

        // Simultaneous exception and branch in IDLE: exception wins.
        reset     = 1'b1;
        exc_valid = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h900;
        tick();
        exc_valid = 1'b0;
        br_valid  = 1'b0;
        chk_state("idle_exc", 1'b1, 32'h80, 1'b0);
        tick();
        check("idle_exc_step", fetch_pc, 32'h84);

        // Misaligned branch target.
        br_valid  = 1'b1;
        br_target = 32'h102;
        tick();
        br_valid = 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        check("misalign.pc", fetch_pc, 32'h80);
        check("misalign.err", 32'(misalign_err), 32'h1);
`else
        check("misalign.pc", fetch_pc, 32'h102);
        check("misalign.err", 32'(misalign_err), 32'h0);
`endif
        tick();
        check("misalign.clear", 32'(misalign_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
